// File: rtl/ws2812_rx.sv
// ---------------------------------------------------------------------------
// ws2812_rx
//
// WS2812 single-wire stream decoder. It samples the serial data line and
// measures the width of every high pulse. Each pulse becomes a 0 or 1 bit,
// and the bits are packed MSB first into 24-bit GRB pixel words. A long low
// run on the line (the latch interval) closes the current frame.
//
// The block serves two purposes. It is the loopback self-test receiver for
// the LED driver, and it can sniff the pixel stream on the LED connector.
//
// Parameters
//   BIT_THRESH  high width (clocks) at or above which a bit decodes as 1
//   MIN_HIGH    high widths below this are glitches (protocol error)
//   MAX_HIGH    high widths above this are protocol errors
//   RST_LOW     consecutive low clocks that form the latch/reset interval
//
// Ports
//   sys_clk     system clock, single clock domain
//   sys_rst_n   asynchronous active-low reset
//   din         WS2812 data line, asynchronous to sys_clk
//   pix_data    last completed pixel word, first received bit in [23]
//   pix_valid   one-cycle strobe, pix_data/pix_idx valid in this cycle
//   pix_idx     index of the pixel in pix_data within the current frame
//   frame_done  one-cycle strobe at end of a frame
//   frame_len   completed pixels in the last frame, updated with frame_done
//   err         one-cycle strobe on any protocol violation
// ---------------------------------------------------------------------------
module ws2812_rx #(
   parameter int BIT_THRESH = 27,
   parameter int MIN_HIGH   = 5,
   parameter int MAX_HIGH   = 60,
   parameter int RST_LOW    = 2500
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic        din,
   output logic [23:0] pix_data,
   output logic        pix_valid,
   output logic [8:0]  pix_idx,
   output logic        frame_done,
   output logic [8:0]  frame_len,
   output logic        err
);

   localparam logic [6:0]  BIT_THRESH_C = 7'(BIT_THRESH);
   localparam logic [6:0]  MIN_HIGH_C   = 7'(MIN_HIGH);
   localparam logic [6:0]  MAX_HIGH_C   = 7'(MAX_HIGH);
   localparam logic [11:0] RST_LOW_C    = 12'(RST_LOW);

   typedef enum logic [1:0] {
      S_ARM,
      S_LOW,
      S_HIGH
   } state_e;

   state_e      state_q, state_d;
   logic        sync1_q;
   logic        din_s_q;
   logic [6:0]  hcnt_q, hcnt_d;
   logic [11:0] lcnt_q, lcnt_d;
   logic [4:0]  bit_cnt_q, bit_cnt_d;
   logic [8:0]  pix_cnt_q, pix_cnt_d;
   logic [23:0] shreg_q, shreg_d;
   logic [23:0] pix_data_q, pix_data_d;
   logic        pix_valid_q, pix_valid_d;
   logic [8:0]  pix_idx_q, pix_idx_d;
   logic        frame_done_q, frame_done_d;
   logic [8:0]  frame_len_q, frame_len_d;
   logic        err_q, err_d;
   logic        new_bit;
   logic [8:0]  pix_cnt_inc;

   // Two-flop synchronizer for the asynchronous data line. Both edges of din
   // see the same two-clock delay, so pulse widths on din_s match din exactly.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         sync1_q <= 1'b0;
         din_s_q <= 1'b0;
      end else begin
         sync1_q <= din;
         din_s_q <= sync1_q;
      end
   end

   // State, counters and registered outputs all update together.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q      <= S_ARM;
         hcnt_q       <= '0;
         lcnt_q       <= '0;
         bit_cnt_q    <= '0;
         pix_cnt_q    <= '0;
         shreg_q      <= '0;
         pix_data_q   <= '0;
         pix_valid_q  <= 1'b0;
         pix_idx_q    <= '0;
         frame_done_q <= 1'b0;
         frame_len_q  <= '0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         hcnt_q       <= hcnt_d;
         lcnt_q       <= lcnt_d;
         bit_cnt_q    <= bit_cnt_d;
         pix_cnt_q    <= pix_cnt_d;
         shreg_q      <= shreg_d;
         pix_data_q   <= pix_data_d;
         pix_valid_q  <= pix_valid_d;
         pix_idx_q    <= pix_idx_d;
         frame_done_q <= frame_done_d;
         frame_len_q  <= frame_len_d;
         err_q        <= err_d;
      end
   end

   // The pixel counter saturates so that very long frames report 511
   // instead of wrapping back to zero.
   assign pix_cnt_inc = (pix_cnt_q == 9'd511) ? pix_cnt_q : pix_cnt_q + 9'd1;

   // Next-state logic. S_ARM waits for a full latch-length low run before it
   // trusts the line. S_LOW times the gap after each bit. S_HIGH measures
   // the pulse and decodes it on the falling edge.
   always_comb begin
      state_d      = state_q;
      hcnt_d       = hcnt_q;
      lcnt_d       = lcnt_q;
      bit_cnt_d    = bit_cnt_q;
      pix_cnt_d    = pix_cnt_q;
      shreg_d      = shreg_q;
      pix_data_d   = pix_data_q;
      pix_valid_d  = 1'b0;
      pix_idx_d    = pix_idx_q;
      frame_done_d = 1'b0;
      frame_len_d  = frame_len_q;
      err_d        = 1'b0;
      new_bit      = 1'b0;

      case (state_q)
         S_ARM: begin
            // Pulses here are ignored. A high only restarts the low-run count.
            if (din_s_q) begin
               lcnt_d = '0;
            end else if (lcnt_q + 12'd1 >= RST_LOW_C) begin
               lcnt_d    = RST_LOW_C;
               state_d   = S_LOW;
               bit_cnt_d = '0;
               pix_cnt_d = '0;
               shreg_d   = '0;
            end else begin
               lcnt_d = lcnt_q + 12'd1;
            end
         end

         S_LOW: begin
            if (din_s_q) begin
               state_d = S_HIGH;
               hcnt_d  = 7'd1;
               lcnt_d  = '0;
            end else if (lcnt_q < RST_LOW_C) begin
               lcnt_d = lcnt_q + 12'd1;
               // lcnt saturates at RST_LOW, so the frame end fires only once
               // per low run. Arriving from S_ARM with a full count never
               // fires it.
               if (lcnt_q + 12'd1 == RST_LOW_C) begin
                  if ((pix_cnt_q != 9'd0) || (bit_cnt_q != 5'd0)) begin
                     frame_done_d = 1'b1;
                     frame_len_d  = pix_cnt_q;
                  end
                  if (bit_cnt_q != 5'd0) begin
                     err_d = 1'b1;
                  end
                  bit_cnt_d = '0;
                  pix_cnt_d = '0;
                  shreg_d   = '0;
               end
            end
         end

         S_HIGH: begin
            if (din_s_q) begin
               // An over-long high aborts right away, without waiting for
               // the line to fall. The decoder must then re-arm.
               if (hcnt_q >= MAX_HIGH_C) begin
                  err_d     = 1'b1;
                  bit_cnt_d = '0;
                  pix_cnt_d = '0;
                  shreg_d   = '0;
                  lcnt_d    = '0;
                  state_d   = S_ARM;
               end else if (hcnt_q != 7'h7F) begin
                  hcnt_d = hcnt_q + 7'd1;
               end
            end else if (hcnt_q < MIN_HIGH_C) begin
               // A glitch-width pulse. This low cycle already counts
               // toward the re-arm low run.
               err_d     = 1'b1;
               bit_cnt_d = '0;
               pix_cnt_d = '0;
               shreg_d   = '0;
               lcnt_d    = 12'd1;
               state_d   = S_ARM;
            end else begin
               new_bit = (hcnt_q >= BIT_THRESH_C);
               shreg_d = {shreg_q[22:0], new_bit};
               lcnt_d  = 12'd1;
               state_d = S_LOW;
               if (bit_cnt_q == 5'd23) begin
                  pix_data_d  = {shreg_q[22:0], new_bit};
                  pix_idx_d   = pix_cnt_q;
                  pix_valid_d = 1'b1;
                  pix_cnt_d   = pix_cnt_inc;
                  bit_cnt_d   = '0;
               end else begin
                  bit_cnt_d = bit_cnt_q + 5'd1;
               end
            end
         end

         default: begin
            state_d = S_ARM;
            lcnt_d  = '0;
         end
      endcase
   end

   assign pix_data   = pix_data_q;
   assign pix_valid  = pix_valid_q;
   assign pix_idx    = pix_idx_q;
   assign frame_done = frame_done_q;
   assign frame_len  = frame_len_q;
   assign err        = err_q;

endmodule

// File: tb/tb_ws2812_rx.sv
// ---------------------------------------------------------------------------
// tb_ws2812_rx
//
// Self-checking bench for ws2812_rx. Expected pixels and frame lengths are
// queued when the bench drives a stimulus. A monitor pops and compares them
// whenever the DUT strobes. Any strobe that arrives with nothing queued is a
// failure. Pulse-width boundaries come from a table of width vectors.
// ---------------------------------------------------------------------------
module tb_ws2812_rx;

   localparam int BIT_THRESH = 27;
   localparam int MIN_HIGH   = 5;
   localparam int MAX_HIGH   = 60;
   localparam int RST_LOW    = 2500;

   logic        sys_clk   = 1'b0;
   logic        sys_rst_n = 1'b0;
   logic        din       = 1'b0;
   logic [23:0] pix_data;
   logic        pix_valid;
   logic [8:0]  pix_idx;
   logic        frame_done;
   logic [8:0]  frame_len;
   logic        err;

   typedef struct {
      logic [23:0] data;
      logic [8:0]  idx;
   } pix_exp_t;

   typedef struct {
      int   width;
      logic expErr;
      logic expBit;
   } width_vec_t;

   pix_exp_t   pixQ[$];
   int         frameQ[$];
   width_vec_t vecs[6];

   int vectorCount  = 0;
   int missCount    = 0;
   int errCount     = 0;
   int errWithFrame = 0;
   int pixSeen      = 0;
   int expIdx       = 0;

   ws2812_rx #(
      .BIT_THRESH(BIT_THRESH),
      .MIN_HIGH  (MIN_HIGH),
      .MAX_HIGH  (MAX_HIGH),
      .RST_LOW   (RST_LOW)
   ) dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .din       (din),
      .pix_data  (pix_data),
      .pix_valid (pix_valid),
      .pix_idx   (pix_idx),
      .frame_done(frame_done),
      .frame_len (frame_len),
      .err       (err)
   );

   // 50 MHz system clock
   always #10 sys_clk = ~sys_clk;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      vectorCount++;
      if (actual !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Output strobes are sampled on the falling clock edge, away from the
   // edge that updates them, and matched against the expectation queues.
   always @(negedge sys_clk) begin
      if (sys_rst_n) begin
         if (err) errCount++;
         if (err && frame_done) errWithFrame++;
         if (pix_valid) begin
            pixSeen++;
            if (pixQ.size() == 0) begin
               vectorCount++;
               missCount++;
               $display("[TB] FAIL unexpected pix_valid: got data 0x%06h idx %0d, expected no strobe",
                        pix_data, pix_idx);
            end else begin
               pix_exp_t e;
               e = pixQ.pop_front();
               checkOutput("pix_data", 32'(pix_data), 32'(e.data));
               checkOutput("pix_idx", 32'(pix_idx), 32'(e.idx));
            end
         end
         if (frame_done) begin
            if (frameQ.size() == 0) begin
               vectorCount++;
               missCount++;
               $display("[TB] FAIL unexpected frame_done: got frame_len %0d, expected no strobe",
                        frame_len);
            end else begin
               checkOutput("frame_len", 32'(frame_len), 32'(frameQ.pop_front()));
            end
         end
      end
   end

   // Drives one high pulse of hi clocks followed by lo clocks of low line.
   task automatic sendPulse(input int hi, input int lo);
      din = 1'b1;
      repeat (hi) @(negedge sys_clk);
      din = 1'b0;
      repeat (lo) @(negedge sys_clk);
   endtask

   task automatic sendPixel(input logic [23:0] data, input int hi0, input int hi1,
                            input int lo);
      for (int i = 23; i >= 0; i--) sendPulse(data[i] ? hi1 : hi0, lo);
   endtask

   task automatic idle(input int n);
      din = 1'b0;
      repeat (n) @(negedge sys_clk);
   endtask

   task automatic expectPixel(input logic [23:0] data, input int idx);
      pix_exp_t e;
      e.data = data;
      e.idx  = 9'(idx);
      pixQ.push_back(e);
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, " pix_data"},   32'(pix_data),   32'h0);
      checkOutput({tag, " pix_valid"},  32'(pix_valid),  32'h0);
      checkOutput({tag, " pix_idx"},    32'(pix_idx),    32'h0);
      checkOutput({tag, " frame_done"}, 32'(frame_done), 32'h0);
      checkOutput({tag, " frame_len"},  32'(frame_len),  32'h0);
      checkOutput({tag, " err"},        32'(err),        32'h0);
   endtask

   task automatic checkDrained(input string tag);
      checkOutput({tag, " pixels outstanding"}, 32'(pixQ.size()), 32'h0);
      checkOutput({tag, " frames outstanding"}, 32'(frameQ.size()), 32'h0);
   endtask

   // One width vector: 23 fixed bits, then the bit under test.
   task automatic applyStimulus(input width_vec_t v);
      logic [23:0] base;
      int          e0;
      base = 24'hA5A5A4;
      e0   = errCount;
      for (int i = 23; i >= 1; i--) sendPulse(base[i] ? 35 : 8, 3);
      if (!v.expErr) begin
         expectPixel({base[23:1], v.expBit}, expIdx);
         sendPulse(v.width, 3);
         expIdx++;
         repeat (4) @(negedge sys_clk);
         checkOutput($sformatf("width %0d no err", v.width), 32'(errCount - e0), 32'd0);
      end else if (v.width > MAX_HIGH) begin
         din = 1'b1;
         repeat (v.width + 4) @(negedge sys_clk);
         checkOutput($sformatf("width %0d err while high", v.width), 32'(errCount - e0), 32'd1);
         idle(RST_LOW + 20);
         expIdx = 0;
      end else begin
         sendPulse(v.width, 4);
         checkOutput($sformatf("width %0d err at fall", v.width), 32'(errCount - e0), 32'd1);
         idle(RST_LOW + 20);
         expIdx = 0;
      end
   endtask

   initial begin
      int e0;
      int ef;
      int p0;

      vecs[0] = '{width: 26, expErr: 1'b0, expBit: 1'b0};
      vecs[1] = '{width: 27, expErr: 1'b0, expBit: 1'b1};
      vecs[2] = '{width: 5,  expErr: 1'b0, expBit: 1'b0};
      vecs[3] = '{width: 4,  expErr: 1'b1, expBit: 1'b0};
      vecs[4] = '{width: 60, expErr: 1'b0, expBit: 1'b1};
      vecs[5] = '{width: 61, expErr: 1'b1, expBit: 1'b0};

      // Reset values, then arm with a full latch-length low run
      sys_rst_n = 1'b0;
      din       = 1'b0;
      repeat (3) @(negedge sys_clk);
      checkResetOutputs("reset");
      sys_rst_n = 1'b1;
      idle(RST_LOW + 20);

      // Single pixel with driver timing
      e0 = errCount;
      expectPixel(24'hFF0055, 0);
      frameQ.push_back(1);
      sendPixel(24'hFF0055, 15, 40, 40);
      idle(RST_LOW + 20);
      checkDrained("single");
      checkOutput("single err count", 32'(errCount - e0), 32'd0);
      checkOutput("single pix_data hold", 32'(pix_data), 32'hFF0055);
      checkOutput("single frame_len hold", 32'(frame_len), 32'd1);

      // 65 back-to-back pixels, one long low run, exactly one frame_done
      e0 = errCount;
      frameQ.push_back(65);
      for (int i = 0; i < 65; i++) begin
         expectPixel(24'(i), i);
         sendPixel(24'(i), 8, 35, 3);
      end
      idle(6000);
      checkDrained("burst");
      checkOutput("burst err count", 32'(errCount - e0), 32'd0);
      checkOutput("burst pix_idx hold", 32'(pix_idx), 32'd64);

      // Pulse-width boundaries
      expIdx = 0;
      foreach (vecs[k]) applyStimulus(vecs[k]);
      repeat (5) @(negedge sys_clk);
      checkDrained("widths");

      // Partial word: frame_done and err together
      e0 = errCount;
      ef = errWithFrame;
      expectPixel(24'h00FF00, 0);
      expectPixel(24'h0F0F0F, 1);
      frameQ.push_back(2);
      sendPixel(24'h00FF00, 8, 35, 3);
      sendPixel(24'h0F0F0F, 8, 35, 3);
      for (int i = 0; i < 10; i++) sendPulse(35, 3);
      idle(RST_LOW + 20);
      checkDrained("partial");
      checkOutput("partial err count", 32'(errCount - e0), 32'd1);
      checkOutput("partial err with frame_done", 32'(errWithFrame - ef), 32'd1);

      // Startup with the line high: pulses are ignored until a latch low
      din       = 1'b1;
      sys_rst_n = 1'b0;
      repeat (3) @(negedge sys_clk);
      checkResetOutputs("startup reset");
      sys_rst_n = 1'b1;
      repeat (1000) @(negedge sys_clk);
      p0 = pixSeen;
      sendPixel(24'h5A5A5A, 15, 40, 40);
      sendPixel(24'hA5A5A5, 15, 40, 40);
      repeat (10) @(negedge sys_clk);
      checkOutput("startup unarmed pixels", 32'(pixSeen - p0), 32'd0);
      idle(RST_LOW + 20);
      expectPixel(24'h123456, 0);
      frameQ.push_back(1);
      sendPixel(24'h123456, 8, 35, 3);
      idle(RST_LOW + 20);
      checkDrained("startup");

      // Reset in the middle of pixel 3
      for (int i = 0; i < 3; i++) begin
         expectPixel(24'hC00001 + 24'(i), i);
         sendPixel(24'hC00001 + 24'(i), 8, 35, 3);
      end
      for (int i = 23; i >= 12; i--) sendPulse(24'hABCDEF >> i & 1 ? 35 : 8, 3);
      din = 1'b1;
      repeat (10) @(negedge sys_clk);
      sys_rst_n = 1'b0;
      #1;
      checkResetOutputs("mid-pixel reset");
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      p0 = pixSeen;
      repeat (25) @(negedge sys_clk);
      din = 1'b0;
      repeat (3) @(negedge sys_clk);
      for (int i = 10; i >= 0; i--) sendPulse(35, 3);
      sendPixel(24'h777777, 8, 35, 3);
      repeat (10) @(negedge sys_clk);
      checkOutput("post-reset ignored pixels", 32'(pixSeen - p0), 32'd0);
      idle(RST_LOW + 20);
      expectPixel(24'h3C3C3C, 0);
      frameQ.push_back(1);
      sendPixel(24'h3C3C3C, 8, 35, 3);
      idle(RST_LOW + 20);
      checkDrained("post-reset");
      checkOutput("post-reset pix_data hold", 32'(pix_data), 32'h3C3C3C);

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule
